// File: rtl/relu_grad_gate_if.sv
// Stream bundle for relu_grad_gate: forward-mask push stream, gradient input
// stream, gated gradient output stream and the mask occupancy count.
interface relu_grad_gate_if #(
  parameter int ACC_W = 64,
  parameter int CNT_W = 9
);
  logic [ACC_W-1:0] fwd_data;
  logic             fwd_valid;
  logic             fwd_ready;
  logic [ACC_W-1:0] grad_in;
  logic             grad_in_valid;
  logic             grad_in_ready;
  logic [ACC_W-1:0] grad_out;
  logic             grad_out_valid;
  logic             grad_out_ready;
  logic [CNT_W-1:0] mask_count;

  modport master (
    output fwd_data, fwd_valid, grad_in, grad_in_valid, grad_out_ready,
    input  fwd_ready, grad_in_ready, grad_out, grad_out_valid, mask_count
  );

  modport slave (
    input  fwd_data, fwd_valid, grad_in, grad_in_valid, grad_out_ready,
    output fwd_ready, grad_in_ready, grad_out, grad_out_valid, mask_count
  );
endinterface

// File: rtl/relu_grad_gate.sv
// ReLU backward gate: stores one derivative bit per forward input in a FIFO and
// uses those bits, in order, to pass or zero the upstream gradient stream.
module relu_grad_gate #(
  parameter int ACC_W = 64,
  parameter int DEPTH = 256,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  relu_grad_gate_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] mask_mem;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;

  logic empty;
  logic fwd_ready;
  logic grad_in_ready;
  logic push;
  logic pop;
  logic mask_in;
  logic mask_rd;

  // Strictly positive: sign bit clear and not zero, so the derivative at 0 is 0.
  assign mask_in = !bus.fwd_data[ACC_W-1] && (|bus.fwd_data);
  assign empty   = (wr_ptr == rd_ptr);
  assign mask_rd = mask_mem[rd_ptr[AW-1:0]];

  // NOTE: readies fold in rst_n and flush so no handshake can complete in a
  // cycle whose state update is being overridden by the clear.
  assign fwd_ready     = rst_n && !flush && (count < CNT_W'(DEPTH));
  assign grad_in_ready = rst_n && !flush && !empty && (!out_valid || bus.grad_out_ready);

  assign push = bus.fwd_valid && fwd_ready;
  assign pop  = bus.grad_in_valid && grad_in_ready;

  // NOTE: the mask array carries no reset; the pointers alone define which
  // entries are live, so stale bits are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem[wr_ptr[AW-1:0]] <= mask_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CNT_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (pop) begin
        out_data  <= mask_rd ? bus.grad_in : '0;
        out_valid <= 1'b1;
      end else if (bus.grad_out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.fwd_ready      = fwd_ready;
  assign bus.grad_in_ready  = grad_in_ready;
  assign bus.grad_out       = out_data;
  assign bus.grad_out_valid = out_valid;
  assign bus.mask_count     = count;

endmodule

// File: tb/tb_relu_grad_gate.sv
// Bench for relu_grad_gate: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_relu_grad_gate;

  localparam int ACC_W  = 64;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int N_RAND = 2 * DEPTH + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  relu_grad_gate_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  relu_grad_gate #(.ACC_W(ACC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: stored mask bits in order, plus the output register.
  bit          mq[$];
  bit          m_valid = 1'b0;
  logic [63:0] m_data  = '0;
  bit          live    = 1'b0;
  logic [63:0] obs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_fwd_ready();
    return rst_n && !flush && (mq.size() < DEPTH);
  endfunction

  function automatic bit exp_grad_in_ready();
    return rst_n && !flush && (mq.size() > 0) && (!m_valid || bus.grad_out_ready);
  endfunction

  // Model update on each rising edge, using inputs driven 1 time unit after the previous edge.
  initial begin
    bit fr;
    bit gr;
    bit m;
    forever begin
      @(posedge clk);
      fr = exp_fwd_ready();
      gr = exp_grad_in_ready();
      if (!rst_n || flush) begin
        mq.delete();
        m_valid = 1'b0;
        m_data  = '0;
        live    = 1'b1;
      end else begin
        if (bus.grad_in_valid && gr) begin
          m       = mq.pop_front();
          m_data  = m ? bus.grad_in : 64'd0;
          m_valid = 1'b1;
        end else if (bus.grad_out_ready) begin
          m_valid = 1'b0;
        end
        if (bus.fwd_valid && fr) begin
          mq.push_back($signed(bus.fwd_data) > 0);
        end
      end
    end
  end

  // Compare process: every falling edge once the model has seen a reset.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        check("mask_count",     64'(bus.mask_count),     64'(mq.size()));
        check("fwd_ready",      64'(bus.fwd_ready),      64'(exp_fwd_ready()));
        check("grad_in_ready",  64'(bus.grad_in_ready),  64'(exp_grad_in_ready()));
        check("grad_out_valid", 64'(bus.grad_out_valid), 64'(m_valid));
        check("grad_out",       bus.grad_out,            m_data);
        if (bus.grad_out_valid && bus.grad_out_ready) obs.push_back(bus.grad_out);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fwd_valid      = 1'b0;
    bus.grad_in_valid  = 1'b0;
    bus.grad_out_ready = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    bus.fwd_valid      = 1'b0;
    bus.grad_in_valid  = 1'b1;
    bus.grad_out_ready = 1'b1;
    while (bus.mask_count != 0 && n < 4 * DEPTH) begin
      bus.grad_in = {$urandom, $urandom};
      step();
      n++;
    end
    bus.grad_in_valid = 1'b0;
    step();
    check("drain_count", 64'(bus.mask_count), 64'd0);
  endtask

  // Load four bits, leave one output stalled, then clear via flush or reset.
  task automatic clear_scenario(input bit use_reset, input string tag);
    logic [63:0] vals[4] = '{64'd1, -64'sd1, 64'd2, 64'd3};
    for (int i = 0; i < 4; i++) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_data  = vals[i];
      step();
    end
    bus.fwd_valid      = 1'b0;
    bus.grad_out_ready = 1'b0;
    bus.grad_in_valid  = 1'b1;
    bus.grad_in        = 64'd77;
    step();
    #1;
    check({tag, "_pre_valid"}, 64'(bus.grad_out_valid), 64'd1);
    check({tag, "_pre_data"},  bus.grad_out,             64'd77);
    if (use_reset) rst_n = 1'b0;
    else           flush = 1'b1;
    #1;
    check({tag, "_cyc_fwd_ready"},  64'(bus.fwd_ready),     64'd0);
    check({tag, "_cyc_grad_ready"}, 64'(bus.grad_in_ready), 64'd0);
    step();
    rst_n = 1'b1;
    flush = 1'b0;
    #1;
    check({tag, "_count"},      64'(bus.mask_count),     64'd0);
    check({tag, "_valid"},      64'(bus.grad_out_valid), 64'd0);
    check({tag, "_data"},       bus.grad_out,            64'd0);
    check({tag, "_grad_ready"}, 64'(bus.grad_in_ready),  64'd0);
    idle_inputs();
    step();
  endtask

  initial begin
    logic [63:0] t1_fwd[5]  = '{64'd5, -64'sd3, 64'd0, 64'd1, -64'sd1};
    logic [63:0] t1_grad[5] = '{64'd10, 64'd20, 64'd30, -64'sd40, 64'd50};
    logic [63:0] t1_exp[5]  = '{64'd10, 64'd0, 64'd0, -64'sd40, 64'd0};
    int pushes;
    int n;
    int sel;

    bus.fwd_data       = '0;
    bus.fwd_valid      = 1'b0;
    bus.grad_in        = '0;
    bus.grad_in_valid  = 1'b0;
    bus.grad_out_ready = 1'b0;

    // Reset state
    step();
    #1;
    check("rst_fwd_ready",  64'(bus.fwd_ready),      64'd0);
    check("rst_grad_ready", 64'(bus.grad_in_ready),  64'd0);
    check("rst_valid",      64'(bus.grad_out_valid), 64'd0);
    check("rst_data",       bus.grad_out,            64'd0);
    check("rst_count",      64'(bus.mask_count),     64'd0);
    step();
    rst_n = 1'b1;
    idle_inputs();
    step();

    // Mixed-sign masks gate a gradient sequence
    for (int i = 0; i < 5; i++) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_data  = t1_fwd[i];
      step();
    end
    bus.fwd_valid = 1'b0;
    #1;
    check("t1_count_full", 64'(bus.mask_count), 64'd5);
    obs.delete();
    for (int i = 0; i < 5; i++) begin
      bus.grad_in_valid = 1'b1;
      bus.grad_in       = t1_grad[i];
      step();
    end
    bus.grad_in_valid = 1'b0;
    step();
    check("t1_obs_size", 64'(obs.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < obs.size()) check($sformatf("t1_out%0d", i), obs[i], t1_exp[i]);
    end
    check("t1_count_empty", 64'(bus.mask_count), 64'd0);

    // Fill to DEPTH, then pop-only followed by pop+push
    for (int i = 0; i < DEPTH; i++) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_data  = 64'(i + 1);
      step();
    end
    bus.fwd_valid = 1'b0;
    #1;
    check("t2_full_ready", 64'(bus.fwd_ready),  64'd0);
    check("t2_full_count", 64'(bus.mask_count), 64'(DEPTH));
    bus.fwd_valid     = 1'b1;
    bus.fwd_data      = 64'd9;
    bus.grad_in_valid = 1'b1;
    bus.grad_in       = 64'd4;
    step();
    step();
    bus.fwd_valid     = 1'b0;
    bus.grad_in_valid = 1'b0;
    #1;
    check("t2_pushpop_count", 64'(bus.mask_count), 64'(DEPTH - 1));
    drain();

    // Push into an empty FIFO while a gradient waits: no bypass
    bus.fwd_valid     = 1'b1;
    bus.fwd_data      = 64'd7;
    bus.grad_in_valid = 1'b1;
    bus.grad_in       = -64'sd9;
    #1;
    check("t3_empty_ready", 64'(bus.grad_in_ready), 64'd0);
    step();
    bus.fwd_valid = 1'b0;
    #1;
    check("t3_next_ready", 64'(bus.grad_in_ready), 64'd1);
    step();
    bus.grad_in_valid = 1'b0;
    #1;
    check("t3_out_valid", 64'(bus.grad_out_valid), 64'd1);
    check("t3_out_data",  bus.grad_out,            -64'sd9);
    step();

    // Downstream stall for three cycles
    bus.fwd_valid = 1'b1;
    bus.fwd_data  = 64'd3;
    step();
    bus.fwd_data  = -64'sd2;
    step();
    bus.fwd_valid      = 1'b0;
    bus.grad_out_ready = 1'b0;
    bus.grad_in_valid  = 1'b1;
    bus.grad_in        = 64'd100;
    step();
    bus.grad_in = 64'd200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_hold_data",  bus.grad_out,            64'd100);
      check("t4_hold_ready", 64'(bus.grad_in_ready),  64'd0);
      check("t4_hold_count", 64'(bus.mask_count),     64'd1);
      step();
    end
    bus.grad_out_ready = 1'b1;
    #1;
    check("t4_release_ready", 64'(bus.grad_in_ready), 64'd1);
    step();
    bus.grad_in_valid = 1'b0;
    #1;
    check("t4_next_valid", 64'(bus.grad_out_valid), 64'd1);
    check("t4_next_data",  bus.grad_out,            64'd0);
    step();

    // Randomized traffic across several pointer wraps
    pushes = 0;
    n      = 0;
    while ((pushes < N_RAND || bus.mask_count != 0) && n < 5000) begin
      bus.fwd_valid = (pushes < N_RAND) && ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 4);
      case (sel)
        0:       bus.fwd_data = 64'd0;
        1:       bus.fwd_data = -64'sd1;
        2:       bus.fwd_data = 64'd1;
        default: bus.fwd_data = {$urandom, $urandom};
      endcase
      bus.grad_in_valid  = ($urandom_range(0, 3) != 0);
      bus.grad_in        = {$urandom, $urandom};
      bus.grad_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.fwd_valid && bus.fwd_ready) pushes++;
      step();
      n++;
    end
    check("t5_budget", 64'(n < 5000), 64'd1);
    check("t5_pushes", 64'(pushes),   64'(N_RAND));
    idle_inputs();
    step();
    step();

    // Clear by flush, then by reset
    clear_scenario(1'b0, "t6_flush");
    clear_scenario(1'b1, "t6_reset");

    // Ordering resumes cleanly after the clear
    bus.fwd_valid = 1'b1;
    bus.fwd_data  = 64'd12;
    step();
    bus.fwd_valid     = 1'b0;
    bus.grad_in_valid = 1'b1;
    bus.grad_in       = 64'd55;
    step();
    bus.grad_in_valid = 1'b0;
    #1;
    check("t6_resume_data", bus.grad_out, 64'd55);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_grad_gate.md
Name: relu_grad_gate

Overview:
Backward-pass companion to the forward ReLU activation stage. It captures a one-bit derivative mask from each forward ReLU input into a mask FIFO. Later it reads those mask bits in order to gate the upstream gradient stream: each gradient passes through where the forward input was positive and is zeroed elsewhere. It sits between the loss/gradient path and the MAC backward path, and uses valid/ready handshakes on all streams.

Parameters:
ACC_W, 64, width of forward data and gradient words (signed two's complement)
DEPTH, 256, mask FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of mask_count

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous clear of mask FIFO and output stage
fwd_data  input  ACC_W  signed forward ReLU input (pre-activation)
fwd_valid  input  1  fwd_data valid
fwd_ready  output  1  mask FIFO can accept a bit
grad_in  input  ACC_W  signed upstream gradient
grad_in_valid  input  1  grad_in valid
grad_in_ready  output  1  gradient accepted this cycle if valid
grad_out  output  ACC_W  gated gradient
grad_out_valid  output  1  grad_out valid
grad_out_ready  input  1  downstream accepts grad_out
mask_count  output  CNT_W  number of mask bits currently stored

Behaviour:
- Reset is `rst_n`, synchronous and active-low, on clock `clk`.
- Reset (`rst_n`=0): FIFO read/write pointers cleared; mask_count=0; grad_out=0; grad_out_valid=0. During reset fwd_ready=0 and grad_in_ready=0.
- Mask bit = 1 iff fwd_data > 0 (signed compare). Zero and negative inputs give 0, so the derivative at 0 is defined as 0.
- Push: when fwd_valid && fwd_ready, the mask bit is written at wr_ptr and wr_ptr increments.
  - fwd_ready = (mask_count < DEPTH) && !flush && rst_n.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs differ and the low bits are equal.
  - empty = pointers equal.
- Pop: when grad_in_valid && grad_in_ready, the mask bit at rd_ptr is read and rd_ptr increments.
  - grad_in_ready = !empty && (!grad_out_valid || grad_out_ready) && !flush && rst_n.
- No same-cycle bypass. A bit pushed in cycle N is poppable from cycle N+1 at the earliest. While the FIFO is empty, grad_in_ready=0 even if a push occurs in the same cycle.
- Simultaneous push and pop in one cycle: both execute and mask_count is unchanged. At full, only the pop can occur because fwd_ready=0, even if a pop happens that cycle.
- mask_count is registered: +1 on push only, -1 on pop only, unchanged on both or neither.
- Output stage: a single register, latency 1 cycle from the grad_in handshake to grad_out_valid.
  - On pop: grad_out <= mask ? grad_in : 0, and grad_out_valid <= 1.
  - Else if grad_out_ready: grad_out_valid <= 0. grad_out holds its last value.
  - While grad_out_valid && !grad_out_ready: grad_out and grad_out_valid hold stable and no pop occurs.
  - Full throughput is 1 gradient per cycle when grad_out_ready is held high.
- Gating is a pure select, with no arithmetic or width change. A negative gradient passes unchanged when mask=1.
- flush=1 (registered, priority over all handshakes): pointers cleared, mask_count=0, grad_out_valid=0, grad_out=0. Any in-flight output is discarded. Ready outputs are 0 in the flush cycle.
- Reset or flush mid-stream discards all stored mask bits. Ordering resumes from an empty FIFO.
- Mask storage is a DEPTH x 1 register array or inferred RAM with synchronous write. Read data must be available in the same cycle as the pop handshake (combinational read of the rd_ptr entry).

Test Plan:
- Push fwd_data {5, -3, 0, 1, -64'sd1}, then grad_in {10, 20, 30, -40, 50} with grad_out_ready=1 -> grad_out {10, 0, 0, -40, 0}, one per cycle, each 1 cycle after its handshake; mask_count steps 5 to 0.
- Push DEPTH positive values without popping -> fwd_ready=0 after the DEPTH-th push and mask_count=DEPTH. Then pop one and push one in the same cycle -> mask_count stays DEPTH-1.
- With the FIFO empty, grad_in_valid=1 and fwd_valid=1 in the same cycle -> grad_in_ready=0 that cycle, =1 the next cycle; the gradient is gated by that new mask bit.
- Hold grad_out_ready=0 for 3 cycles after one valid output -> grad_out stable, grad_in_ready=0, mask_count unchanged. Release -> the next gradient is accepted in the same cycle as the release.
- Push 2*DEPTH+3 values with interleaved pops (random ready patterns) -> pointer wrap correct; outputs match a reference model in order.
- Load 4 mask bits, assert flush for 1 cycle with grad_out_valid=1 -> next cycle mask_count=0, grad_out_valid=0, grad_out=0, grad_in_ready=0. Repeat the same sequence with rst_n=0 for 1 cycle -> identical result.
